// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Optional round-robin arbitration is enabled by defining RAM_ARB_RR_EN.
package ram_arb_pkg;

  localparam int RAM_AW = 5;
  localparam int RAM_DW = 8;
  localparam int NPORTS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  function automatic logic [NPORTS-1:0] port_onehot(input logic port);
    port_onehot = port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational 2-way winner select. With RAM_ARB_RR_EN the port not granted
// most recently wins a tie; otherwise port 0 has fixed priority.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic [NPORTS-1:0] req_i,
`ifdef RAM_ARB_RR_EN
  input  logic              last_i,
`endif
  output logic              win_o
);

  always_comb begin
`ifdef RAM_ARB_RR_EN
    win_o = (&req_i) ? ~last_i : req_i[1];
`else
    win_o = ~req_i[0] & req_i[1];
`endif
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-client arbiter/sequencer for the 32x8 single-port RAM (RAM_ARB_RR_EN
// selects round-robin ties). Handshake: a client holds req/we/addr/wdata
// stable until its one-cycle gnt_o pulse and drops req after that cycle;
// read data returns with a one-cycle rvalid_o pulse on the winning port.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    req_i,
  input  logic [NPORTS-1:0]    we_i,
  input  logic [NPORTS*AW-1:0] addr_i,
  input  logic [NPORTS*DW-1:0] wdata_i,
  output logic [NPORTS-1:0]    gnt_o,
  output logic [NPORTS-1:0]    rvalid_o,
  output logic [DW-1:0]        rdata_o,
  output logic [AW-1:0]        ram_addr_o,
  output logic [DW-1:0]        ram_wdata_o,
  output logic                 ram_we_o,
  output logic                 ram_re_o,
  input  logic [DW-1:0]        ram_rdata_i
);

  arb_state_e        state_q, state_d;
  logic [NPORTS-1:0] gnt_q, gnt_d;
  logic [NPORTS-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              cmd_port_q, cmd_port_d;
  logic              cmd_we_q, cmd_we_d;
  logic [AW-1:0]     cmd_addr_q, cmd_addr_d;
  logic [DW-1:0]     cmd_wdata_q, cmd_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_re_q, ram_re_d;
  logic              win;

`ifdef RAM_ARB_RR_EN
  logic last_q, last_d;

  ram_arb_pick u_pick (
    .req_i  (req_i),
    .last_i (last_q),
    .win_o  (win)
  );
`else
  ram_arb_pick u_pick (
    .req_i  (req_i),
    .win_o  (win)
  );
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    cmd_port_d  = cmd_port_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    ram_we_d    = 1'b0;
    ram_re_d    = 1'b0;
`ifdef RAM_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d     = CMD;
          cmd_port_d  = win;
          cmd_we_d    = we_i[win];
          cmd_addr_d  = win ? addr_i[2*AW-1:AW] : addr_i[AW-1:0];
          cmd_wdata_d = win ? wdata_i[2*DW-1:DW] : wdata_i[DW-1:0];
          // Grant and RAM enables are registered so they line up with CMD.
          gnt_d       = port_onehot(win);
          ram_we_d    = we_i[win];
          ram_re_d    = ~we_i[win];
`ifdef RAM_ARB_RR_EN
          last_d      = win;
`endif
        end
      end
      CMD: begin
        state_d = cmd_we_q ? IDLE : RESP;
      end
      RESP: begin
        state_d  = IDLE;
        rdata_d  = ram_rdata_i;
        rvalid_d = port_onehot(cmd_port_q);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      cmd_port_q  <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
`ifdef RAM_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      cmd_port_q  <= cmd_port_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
`ifdef RAM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign gnt_o       = gnt_q;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign ram_addr_o  = cmd_addr_q;
  assign ram_wdata_o = cmd_wdata_q;
  assign ram_we_o    = ram_we_q;
  assign ram_re_o    = ram_re_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter with a behavioural 32x8 RAM (registered read).
// Tie expectations follow RAM_ARB_RR_EN when it is defined for the build.
module tb_ram_port_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [9:0]  addr_i;
  logic [15:0] wdata_i;
  logic [1:0]  gnt_o;
  logic [1:0]  rvalid_o;
  logic [7:0]  rdata_o;
  logic [4:0]  ram_addr_o;
  logic [7:0]  ram_wdata_o;
  logic        ram_we_o;
  logic        ram_re_o;
  logic [7:0]  ram_rdata_i;

  int checks   = 0;
  int failures = 0;

  ram_port_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_we_o    (ram_we_o),
    .ram_re_o    (ram_re_o),
    .ram_rdata_i (ram_rdata_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // RAM model; its reset is tied to the system reset
  logic [7:0] mem [32];
  always @(posedge clk) begin
    if (!reset) begin
      ram_rdata_i <= 8'h00;
    end else begin
      if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
      if (ram_re_o) ram_rdata_i <= mem[ram_addr_o];
    end
  end

  // write and read enables must never be high together
  always @(negedge clk) begin
    checks++;
    if (ram_we_o && ram_re_o) begin
      failures++;
      $display("FAIL we_re_excl: got we=%0b re=%0b expected not both 1", ram_we_o, ram_re_o);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] we,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    req_i   = req;
    we_i    = we;
    addr_i  = {a1, a0};
    wdata_i = {d1, d0};
  endtask

  task automatic chk_all(input string tag, input logic [1:0] gnt, input logic we,
                         input logic re, input logic [4:0] addr, input logic [7:0] wdata,
                         input logic [1:0] rv, input logic [7:0] rd);
    chk({tag, ".gnt"},    32'(gnt_o),       32'(gnt));
    chk({tag, ".we"},     32'(ram_we_o),    32'(we));
    chk({tag, ".re"},     32'(ram_re_o),    32'(re));
    chk({tag, ".addr"},   32'(ram_addr_o),  32'(addr));
    chk({tag, ".wdata"},  32'(ram_wdata_o), 32'(wdata));
    chk({tag, ".rvalid"}, 32'(rvalid_o),    32'(rv));
    chk({tag, ".rdata"},  32'(rdata_o),     32'(rd));
  endtask

  typedef struct {
    logic [1:0] req;
    logic [1:0] we;
    logic [4:0] a0;
    logic [4:0] a1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] e_gnt;
    logic       e_we;
    logic       e_re;
    logic [4:0] e_addr;
    logic [7:0] e_wdata;
    logic [1:0] e_rv;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vecs [15];

  // scoreboard of expected read returns: {port, data}
  logic [8:0] exp_q[$];

  initial begin
    logic [8:0] e;
    logic       exp_port;
    int         ng;
    int         nrv;

    // port 0 write/read addr 3, port 1 write/read addr 31, then tie writes
    vecs[0]  = '{2'b01, 2'b01, 5'd3, 5'd0,  8'hA5, 8'h00, 2'b01, 1'b1, 1'b0, 5'd3,  8'hA5, 2'b00, 8'h00};
    vecs[1]  = '{2'b00, 2'b00, 5'd0, 5'd0,  8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 5'd3,  8'hA5, 2'b00, 8'h00};
    vecs[2]  = '{2'b01, 2'b00, 5'd3, 5'd0,  8'h00, 8'h00, 2'b01, 1'b0, 1'b1, 5'd3,  8'h00, 2'b00, 8'h00};
    vecs[3]  = '{2'b00, 2'b00, 5'd0, 5'd0,  8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 5'd3,  8'h00, 2'b00, 8'h00};
    vecs[4]  = '{2'b00, 2'b00, 5'd0, 5'd0,  8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 5'd3,  8'h00, 2'b01, 8'hA5};
    vecs[5]  = '{2'b00, 2'b00, 5'd0, 5'd0,  8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 5'd3,  8'h00, 2'b00, 8'hA5};
    vecs[6]  = '{2'b10, 2'b10, 5'd0, 5'd31, 8'h00, 8'h7E, 2'b10, 1'b1, 1'b0, 5'd31, 8'h7E, 2'b00, 8'hA5};
    vecs[7]  = '{2'b00, 2'b00, 5'd0, 5'd0,  8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 5'd31, 8'h7E, 2'b00, 8'hA5};
    vecs[8]  = '{2'b10, 2'b00, 5'd0, 5'd31, 8'h00, 8'h00, 2'b10, 1'b0, 1'b1, 5'd31, 8'h00, 2'b00, 8'hA5};
    vecs[9]  = '{2'b00, 2'b00, 5'd0, 5'd0,  8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 5'd31, 8'h00, 2'b00, 8'hA5};
    vecs[10] = '{2'b00, 2'b00, 5'd0, 5'd0,  8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 5'd31, 8'h00, 2'b10, 8'h7E};
    vecs[11] = '{2'b11, 2'b11, 5'd1, 5'd2,  8'h11, 8'h22, 2'b01, 1'b1, 1'b0, 5'd1,  8'h11, 2'b00, 8'h7E};
    vecs[12] = '{2'b10, 2'b10, 5'd0, 5'd2,  8'h00, 8'h22, 2'b00, 1'b0, 1'b0, 5'd1,  8'h11, 2'b00, 8'h7E};
    vecs[13] = '{2'b10, 2'b10, 5'd0, 5'd2,  8'h00, 8'h22, 2'b10, 1'b1, 1'b0, 5'd2,  8'h22, 2'b00, 8'h7E};
    vecs[14] = '{2'b00, 2'b00, 5'd0, 5'd0,  8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 5'd2,  8'h22, 2'b00, 8'h7E};

    // reset state
    reset = 1'b0;
    drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
    tick();
    tick();
    chk_all("reset", 2'b00, 1'b0, 1'b0, 5'd0, 8'h00, 2'b00, 8'h00);
    reset = 1'b1;

    // table-driven single-port and tie-write vectors
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].req, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_we, vecs[i].e_re,
              vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_rv, vecs[i].e_rd);
    end

    // both ports reading continuously; each client drops req for one cycle after gnt
    drive(2'b11, 2'b00, 5'd1, 5'd2, 8'h00, 8'h00);
    ng  = 0;
    nrv = 0;
    for (int cyc = 0; cyc < 100 && nrv < 6; cyc++) begin
      tick();
      if (gnt_o != 2'b00) begin
`ifdef RAM_ARB_RR_EN
        exp_port = ng[0];
`else
        exp_port = 1'b0;
`endif
        chk($sformatf("tie_gnt%0d", ng), 32'(gnt_o), exp_port ? 32'h2 : 32'h1);
        exp_q.push_back(exp_port ? {1'b1, 8'h22} : {1'b0, 8'h11});
        ng++;
      end
      if (rvalid_o != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("tie_rv_unexpected", 32'(rvalid_o), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("tie_rv%0d", nrv), 32'(rvalid_o), e[8] ? 32'h2 : 32'h1);
          chk($sformatf("tie_rd%0d", nrv), 32'(rdata_o), 32'(e[7:0]));
        end
        nrv++;
      end
      req_i = (ng >= 6) ? 2'b00 : ~gnt_o;
    end
    chk("tie_done", 32'(nrv), 32'd6);
    req_i = 2'b00;
    tick();
    tick();

    // read of 0x5C, then 20 idle cycles holding rdata
    drive(2'b01, 2'b01, 5'd7, 5'd0, 8'h5C, 8'h00);
    tick();
    req_i = 2'b00;
    tick();
    drive(2'b01, 2'b00, 5'd7, 5'd0, 8'h00, 8'h00);
    tick();
    chk("rd5c_gnt", 32'(gnt_o), 32'h1);
    req_i = 2'b00;
    tick();
    tick();
    chk("rd5c_rv", 32'(rvalid_o), 32'h1);
    chk("rd5c_rd", 32'(rdata_o), 32'h5C);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_gnt", 32'(gnt_o), 32'h0);
      chk("idle_rv", 32'(rvalid_o), 32'h0);
      chk("idle_en", 32'({ram_we_o, ram_re_o}), 32'h0);
      chk("idle_rd", 32'(rdata_o), 32'h5C);
    end

    // reset during RESP of a port-0 read drops the read
    drive(2'b01, 2'b00, 5'd3, 5'd0, 8'h00, 8'h00);
    tick();
    chk("rstmid_gnt", 32'(gnt_o), 32'h1);
    req_i = 2'b00;
    tick();
    reset = 1'b0;
    tick();
    chk_all("rstmid", 2'b00, 1'b0, 1'b0, 5'd0, 8'h00, 2'b00, 8'h00);
    reset = 1'b1;
    tick();
    chk("rstmid_norv0", 32'(rvalid_o), 32'h0);
    tick();
    chk("rstmid_norv1", 32'(rvalid_o), 32'h0);

    // first tie after reset goes to port 0, port 1 follows
    drive(2'b11, 2'b00, 5'd3, 5'd31, 8'h00, 8'h00);
    tick();
    chk("post_rst_tie", 32'(gnt_o), 32'h1);
    req_i = 2'b10;
    tick();
    tick();
    chk("post_rst_rv0", 32'(rvalid_o), 32'h1);
    chk("post_rst_rd0", 32'(rdata_o), 32'hA5);
    tick();
    chk("post_rst_gnt1", 32'(gnt_o), 32'h2);
    req_i = 2'b00;
    tick();
    tick();
    chk("post_rst_rv1", 32'(rvalid_o), 32'h2);
    chk("post_rst_rd1", 32'(rdata_o), 32'h7E);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
